// File: rtl/fetch_unit_btb.sv
// fetch_unit_btb -- PC generator for mips_core with a direct-mapped BTB.
//
// Holds the registered fetch PC and computes the combinational next PC
// (stall > redirect > BTB prediction > sequential +4). A direct-mapped
// branch target buffer with 2-bit saturating counters is looked up on
// the current PC and trained by the execute-stage resolver.
//
// Optional feature: define FETCH_PERF_EN to add two 32-bit performance
// counters (o_perf_redirects, o_perf_pred_taken).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_stall            hold the PC (hazard controller)
//   i_redirect_valid   load i_redirect_pc (jump / mispredict)
//   i_redirect_pc      redirect target
//   i_update_*         BTB training from resolved control flow
//   o_pc_current       registered PC fetched this cycle
//   o_pc_next          combinational next PC (drives the sync i_cache)
//   o_pred_taken       prediction for o_pc_current
//   o_pred_target      predicted target (0 when not taken)
//   o_perf_*           performance counters (FETCH_PERF_EN only)
module fetch_unit_btb #(
  parameter int ADDR_WIDTH = 26,
  parameter int BTB_DEPTH  = 16,
  parameter int IDX_BITS   = $clog2(BTB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  input  logic                  i_update_valid,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_taken,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  output logic [ADDR_WIDTH-1:0] o_pc_current,
  output logic [ADDR_WIDTH-1:0] o_pc_next,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           o_perf_redirects,
  output logic [31:0]           o_perf_pred_taken
`endif
);

  localparam int TAG_W = ADDR_WIDTH - IDX_BITS - 2;

  logic                  valid_q  [BTB_DEPTH];
  logic [1:0]            ctr_q    [BTB_DEPTH];
  logic [TAG_W-1:0]      tag_q    [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [BTB_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q;

  // Lookup side (current PC).
  logic [IDX_BITS-1:0] look_idx;
  logic [TAG_W-1:0]    look_tag;
  logic                look_hit;

  // Update side (resolved instruction PC).
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;

  logic sel_pred;

  // Byte-offset bits never participate in indexing or tagging.
  logic unused_ok;
  assign unused_ok = ^{pc_q[1:0], i_update_pc[1:0]};

  assign look_idx = pc_q[IDX_BITS+1:2];
  assign look_tag = pc_q[ADDR_WIDTH-1:IDX_BITS+2];
  assign upd_idx  = i_update_pc[IDX_BITS+1:2];
  assign upd_tag  = i_update_pc[ADDR_WIDTH-1:IDX_BITS+2];

  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign o_pc_current  = pc_q;
  assign o_pred_taken  = look_hit && ctr_q[look_idx][1];
  assign o_pred_target = o_pred_taken ? target_q[look_idx] : '0;

  // Prediction only steers the PC when neither stall nor redirect wins.
  assign sel_pred = !i_stall && !i_redirect_valid && o_pred_taken;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_pc_next = pc_q + ADDR_WIDTH'(4);
    if (i_stall)               o_pc_next = pc_q;
    else if (i_redirect_valid) o_pc_next = i_redirect_pc;
    else if (o_pred_taken)     o_pc_next = o_pred_target;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is also what makes a same-cycle lookup
  // see the BTB contents from before the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= o_pc_next;
  end

  // Valid bits and counters carry architectural meaning and are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (i_update_valid) begin
      if (upd_hit) begin
        if (i_update_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (i_update_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target storage is deliberately not reset; valid_q gates every
  // use of it, so reset only needs to clear the valid bits.
  // A taken update rewrites the target on a hit and tag+target on an
  // allocation; the tag write on a hit is a no-op since it already matches.
  always_ff @(posedge clk) begin
    if (i_update_valid && i_update_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= i_update_target;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_redirects  <= '0;
      o_perf_pred_taken <= '0;
    end else begin
      if (i_redirect_valid && !i_stall) o_perf_redirects <= o_perf_redirects + 32'd1;
      if (sel_pred)                     o_perf_pred_taken <= o_perf_pred_taken + 32'd1;
    end
  end
`else
  logic unused_sel_pred;
  assign unused_sel_pred = sel_pred;
`endif

endmodule

// File: tb/tb_fetch_unit_btb.sv
// Testbench for fetch_unit_btb (default parameters, BTB_DEPTH=16).
// Directed vectors push the hand-computed expected outputs of each cycle
// into a queue; a monitor on the falling edge pops and compares.
module tb_fetch_unit_btb;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, redir_v, upd_v, upd_taken;
  logic [AW-1:0] redir_pc, upd_pc, upd_tgt;
  logic [AW-1:0] pc_cur, pc_nxt, pred_tgt;
  logic          pred_tk;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_redir, perf_pred;
  logic [31:0]   snap_redir, snap_pred;
`endif

  typedef struct {
    string         name;
    logic [AW-1:0] cur;
    logic [AW-1:0] nxt;
    logic          pt;
    logic [AW-1:0] ptgt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_unit_btb dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (stall),
    .i_redirect_valid (redir_v),
    .i_redirect_pc    (redir_pc),
    .i_update_valid   (upd_v),
    .i_update_pc      (upd_pc),
    .i_update_taken   (upd_taken),
    .i_update_target  (upd_tgt),
    .o_pc_current     (pc_cur),
    .o_pc_next        (pc_nxt),
    .o_pred_taken     (pred_tk),
    .o_pred_target    (pred_tgt)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_redirects  (perf_redir),
    .o_perf_pred_taken (perf_pred)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".pc_current"},  32'(pc_cur),   32'(e.cur));
      check({e.name, ".pc_next"},     32'(pc_nxt),   32'(e.nxt));
      check({e.name, ".pred_taken"},  32'(pred_tk),  32'(e.pt));
      check({e.name, ".pred_target"}, 32'(pred_tgt), 32'(e.ptgt));
    end
  end

  task automatic expect_now(input string name, input logic [AW-1:0] cur,
                            input logic [AW-1:0] nxt, input logic pt,
                            input logic [AW-1:0] ptgt);
    exp_t e;
    e.name = name; e.cur = cur; e.nxt = nxt; e.pt = pt; e.ptgt = ptgt;
    q.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge, push the expectation.
  task automatic step(input string name, input logic st, input logic rv,
                      input logic [AW-1:0] rpc, input logic uv,
                      input logic [AW-1:0] upc, input logic ut,
                      input logic [AW-1:0] utgt, input logic [AW-1:0] cur,
                      input logic [AW-1:0] nxt, input logic pt,
                      input logic [AW-1:0] ptgt);
    @(posedge clk);
    #1;
    stall = st; redir_v = rv; redir_pc = rpc;
    upd_v = uv; upd_pc = upc; upd_taken = ut; upd_tgt = utgt;
    expect_now(name, cur, nxt, pt, ptgt);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 0; redir_v = 0; redir_pc = '0;
    upd_v = 0; upd_pc = '0; upd_taken = 0; upd_tgt = '0;
    #1;
    expect_now("reset", 0, 4, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    //   name       st rv rpc        uv upc   ut utgt    cur        nxt        pt ptgt
    step("run4",    0, 0, 0,         0, 0,    0, 0,      'h4,       'h8,       0, 0);
    step("run8",    0, 0, 0,         0, 0,    0, 0,      'h8,       'hc,       0, 0);
    step("runc",    0, 0, 0,         0, 0,    0, 0,      'hc,       'h10,      0, 0);
    step("stall1",  1, 0, 0,         0, 0,    0, 0,      'h10,      'h10,      0, 0);
    step("stall2",  1, 0, 0,         0, 0,    0, 0,      'h10,      'h10,      0, 0);
    // Redirect ignored while stalled; training proceeds regardless of stall.
    step("stall3",  1, 1, 'h300,     1, 'h20, 1, 'h100,  'h10,      'h10,      0, 0);
    step("release", 0, 0, 0,         0, 0,    0, 0,      'h10,      'h14,      0, 0);
    step("seq14",   0, 0, 0,         0, 0,    0, 0,      'h14,      'h18,      0, 0);
    step("seq18",   0, 0, 0,         0, 0,    0, 0,      'h18,      'h1c,      0, 0);
    step("seq1c",   0, 0, 0,         0, 0,    0, 0,      'h1c,      'h20,      0, 0);
    // Hit ctr=2: predicted; same-cycle not-taken update must not affect lookup.
    step("pred20",  0, 0, 0,         1, 'h20, 0, 0,      'h20,      'h100,     1, 'h100);
    step("tgt100",  0, 0, 0,         1, 'h20, 0, 0,      'h100,     'h104,     0, 0);
    step("redir20", 0, 1, 'h20,      0, 0,    0, 0,      'h104,     'h20,      0, 0);
    // ctr=0: not predicted; one taken update -> ctr=1.
    step("ctr0",    0, 0, 0,         1, 'h20, 1, 'h100,  'h20,      'h24,      0, 0);
    step("redir2",  0, 1, 'h20,      0, 0,    0, 0,      'h24,      'h20,      0, 0);
    // ctr=1: still not predicted; taken update -> ctr=2, new target 0x140.
    step("ctr1",    0, 0, 0,         1, 'h20, 1, 'h140,  'h20,      'h24,      0, 0);
    step("redir3",  0, 1, 'h20,      0, 0,    0, 0,      'h24,      'h20,      0, 0);
    // Predicted, but redirect wins; alias 0x60 allocated in same index.
    step("redirwin",0, 1, 'h200,     1, 'h60, 1, 'h180,  'h20,      'h200,     1, 'h140);
`ifdef FETCH_PERF_EN
    snap_redir = perf_redir; snap_pred = perf_pred;
`endif
    step("to60",    0, 1, 'h60,      0, 0,    0, 0,      'h200,     'h60,      0, 0);
`ifdef FETCH_PERF_EN
    check("perf_redirects",  perf_redir, snap_redir + 32'd1);
    check("perf_pred_taken", perf_pred,  snap_pred);
`endif
    step("pred60",  0, 0, 0,         0, 0,    0, 0,      'h60,      'h180,     1, 'h180);
    step("to20",    0, 1, 'h20,      0, 0,    0, 0,      'h180,     'h20,      0, 0);
    step("alias20", 0, 0, 0,         0, 0,    0, 0,      'h20,      'h24,      0, 0);
    step("towrap",  0, 1, 'h3fffffc, 0, 0,    0, 0,      'h24,      'h3fffffc, 0, 0);
    step("wrap",    0, 0, 0,         0, 0,    0, 0,      'h3fffffc, 'h0,       0, 0);
    step("wrap0",   0, 0, 0,         0, 0,    0, 0,      'h0,       'h4,       0, 0);

    // Asynchronous reset mid-cycle clears the PC and the BTB.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 expect_now("midreset", 0, 4, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step("postrst", 0, 1, 'h60,      0, 0,    0, 0,      'h4,       'h60,      0, 0);
    step("cleared", 0, 0, 0,         0, 0,    0, 0,      'h60,      'h64,      0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit_btb.md
Name: fetch_unit_btb

Overview:
Next-generation PC generator for mips_core. Produces the registered current PC and combinational next PC like the existing fetch stage. Adds a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches are predicted in fetch. Sits between the hazard controller / execute-stage resolver and i_cache. Drives i_cache with o_pc_next (synchronous cache) and fetch/decode with o_pc_current.

Parameters:
ADDR_WIDTH, 26, byte-address width of every PC and target.
BTB_DEPTH, 16, number of BTB entries; power of two, >= 2.
IDX_BITS, $clog2(BTB_DEPTH), derived; BTB index width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
i_stall  input  1  hold PC (hazard controller)
i_redirect_valid  input  1  load PC from execute (jump/mispredict)
i_redirect_pc  input  ADDR_WIDTH  redirect target
i_update_valid  input  1  resolved control-flow instruction this cycle
i_update_pc  input  ADDR_WIDTH  PC of resolved instruction
i_update_taken  input  1  actual direction
i_update_target  input  ADDR_WIDTH  actual taken target
o_pc_current  output  ADDR_WIDTH  registered PC fetched this cycle
o_pc_next  output  ADDR_WIDTH  combinational next PC
o_pred_taken  output  1  prediction attached to o_pc_current
o_pred_target  output  ADDR_WIDTH  predicted target for o_pc_current (0 when not taken)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: o_pc_current=0; all BTB valid bits=0; counters=2'b01; the performance counters (if present)=0. So o_pred_taken=0, o_pred_target=0, o_pc_next=4.
- BTB entry: valid, tag (PC bits [ADDR_WIDTH-1:IDX_BITS+2]), target (ADDR_WIDTH), ctr (2 bits). Index = PC[IDX_BITS+1:2]. PC bits [1:0] are ignored.
- Lookup: combinational on o_pc_current. hit = valid && tag match. o_pred_taken = hit && ctr[1]. o_pred_target = o_pred_taken ? target : 0.
- o_pc_next priority:
  1. i_stall: o_pc_current.
  2. i_redirect_valid: i_redirect_pc.
  3. o_pred_taken: o_pred_target.
  4. Otherwise: o_pc_current + 4, wrapping modulo 2^ADDR_WIDTH.
- A redirect during a stall is ignored. The source holds i_redirect_valid until i_stall is low.
- o_pc_current <= o_pc_next on every posedge. Latency PC->prediction is 0 cycles; prediction affects the next cycle's PC.
- Update, on posedge when i_update_valid, independent of i_stall. Index and tag come from i_update_pc.
  - Hit, taken: ctr = sat-inc (max 3); target = i_update_target.
  - Hit, not taken: ctr = sat-dec (min 0); target unchanged.
  - Miss, taken: allocate/overwrite. valid=1, new tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Update and lookup on the same index in the same cycle: lookup sees pre-update contents; the new value is visible from the next cycle.
- Asynchronous reset mid-operation clears the PC and all BTB valid bits immediately. No partial update survives.

Optional Feature:
FETCH_PERF_EN. When defined, adds two outputs:
- o_perf_redirects (32): increments on each cycle with i_redirect_valid && !i_stall.
- o_perf_pred_taken (32): increments on each cycle where o_pc_next was selected from the BTB.
Both wrap at 2^32 and reset to 0.
When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then free run with no stall/redirect/update -> o_pc_current 0,4,8,12; o_pred_taken=0 throughout.
- i_stall high for 3 cycles at PC=0x10 -> o_pc_current stays 0x10; o_pc_next=0x10. On release, PC goes to 0x14.
- Update pc=0x20, taken, target=0x100, then run to 0x20 -> o_pred_taken=1, o_pc_next=0x100, next o_pc_current=0x100.
- Hit entry 0x20 (ctr=2), then update not-taken twice -> ctr=0. At 0x20, o_pred_taken=0 and o_pc_next=0x24. One taken update returns ctr to 1; still not predicted.
- BTB_DEPTH=16: alias 0x20 and 0x60 (same index, different tag). Taken update at 0x60 -> 0x60 predicted; 0x20 now misses.
- PC=0x20 predicted taken, same cycle i_redirect_valid with i_redirect_pc=0x200 -> o_pc_next=0x200. With FETCH_PERF_EN, o_perf_redirects increments by 1 and o_perf_pred_taken is unchanged.
